waveform_seq_ctrl: RTL and testbench

//   Step sequencer in front of waveform_gen. Holds a small programmable table of

---
 rtl/waveform_seq_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_waveform_seq_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/waveform_seq_ctrl.sv
// rtl/waveform_seq_ctrl.sv - programmable step sequencer driving waveform_gen controls
//
// Purpose: holds a DEPTH-entry table of steps (freq_sel, wave_sel, rec_duty_cyc,
// saw_reverse, dwell) and, once started, applies the steps to the generator
// controls one after another, each for max(dwell,1) clk cycles, with optional
// looping, a level pause and a stop pulse. Owns the generator halt pin.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cfg_we/cfg_addr/cfg_*     table write port (freq, wave, duty, rev, dwell)
//   num_steps, loop_en        run length (sampled on start) and wrap enable
//   start, stop, pause        sequence control (stop > start > pause > advance)
//   freq_sel..saw_reverse     registered generator controls
//   halt                      generator halt, high unless running
//   busy, step_idx            RUN/PAUSED indicator, index of applied step
//   step_strobe, done         new-step pulse, non-looping end pulse

module waveform_seq_ctrl #(
    parameter int SEL_WIDTH   = 8,
    parameter int CNT_WIDTH   = 8,
    parameter int DEPTH       = 8,
    parameter int DWELL_WIDTH = 16,
    localparam int AW         = $clog2(DEPTH),
    localparam int NW         = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_we,
    input  logic [AW-1:0]          cfg_addr,
    input  logic [SEL_WIDTH-1:0]   cfg_freq,
    input  logic [1:0]             cfg_wave,
    input  logic [CNT_WIDTH-1:0]   cfg_duty,
    input  logic                   cfg_rev,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell,
    input  logic [NW-1:0]          num_steps,
    input  logic                   loop_en,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   pause,
    output logic [SEL_WIDTH-1:0]   freq_sel,
    output logic [1:0]             wave_sel,
    output logic [CNT_WIDTH-1:0]   rec_duty_cyc,
    output logic                   saw_reverse,
    output logic                   halt,
    output logic                   busy,
    output logic [AW-1:0]          step_idx,
    output logic                   step_strobe,
    output logic                   done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSED,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [SEL_WIDTH-1:0]   freq;
        logic [1:0]             wave;
        logic [CNT_WIDTH-1:0]   duty;
        logic                   rev;
        logic [DWELL_WIDTH-1:0] dwell;
    } step_t;

    localparam logic [AW:0]   DEPTH_A = (AW + 1)'(DEPTH);
    localparam logic [NW-1:0] DEPTH_N = NW'(DEPTH);

    step_t                  tab_q [DEPTH];
    step_t                  tab_d [DEPTH];
    state_t                 state_q, state_d;
    logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
    logic [AW-1:0]          idx_q, idx_d;
    logic [AW-1:0]          last_idx_q, last_idx_d;
    logic [SEL_WIDTH-1:0]   freq_q, freq_d;
    logic [1:0]             wave_q, wave_d;
    logic [CNT_WIDTH-1:0]   duty_q, duty_d;
    logic                   rev_q, rev_d;
    logic                   halt_q, halt_d;
    logic                   busy_q, busy_d;
    logic                   strobe_q, strobe_d;
    logic                   done_q, done_d;

    logic                   load;
    logic [AW-1:0]          load_idx;
    step_t                  ld_step;
    logic [NW-1:0]          n_clamped;
    logic [NW-1:0]          n_minus1;

    // Table write port: lands in the table the cycle after cfg_we.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            tab_d[i] = tab_q[i];
        end
        if (cfg_we && ({1'b0, cfg_addr} < DEPTH_A)) begin
            tab_d[cfg_addr] = '{freq: cfg_freq, wave: cfg_wave, duty: cfg_duty,
                                rev: cfg_rev, dwell: cfg_dwell};
        end
    end

    always_comb begin
        n_clamped = (num_steps > DEPTH_N) ? DEPTH_N : num_steps;
        n_minus1  = n_clamped - NW'(1);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        last_idx_d = last_idx_q;
        freq_d     = freq_q;
        wave_d     = wave_q;
        duty_d     = duty_q;
        rev_d      = rev_q;
        halt_d     = halt_q;
        busy_d     = busy_q;
        strobe_d   = 1'b0;
        done_d     = 1'b0;
        load       = 1'b0;
        load_idx   = '0;
        ld_step    = '0;

        if (stop) begin
            state_d = S_IDLE;
            halt_d  = 1'b1;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start && (num_steps != '0)) begin
                        load       = 1'b1;
                        load_idx   = '0;
                        last_idx_d = n_minus1[AW-1:0];
                        state_d    = S_RUN;
                        halt_d     = 1'b0;
                        busy_d     = 1'b1;
                    end
                end
                S_RUN: begin
                    if (pause) begin
                        state_d = S_PAUSED;
                        halt_d  = 1'b1;
                    end else if (cnt_q <= DWELL_WIDTH'(1)) begin
                        // Last cycle of the current step.
                        if (idx_q != last_idx_q) begin
                            load     = 1'b1;
                            load_idx = idx_q + AW'(1);
                        end else if (loop_en) begin
                            load     = 1'b1;
                            load_idx = '0;
                        end else begin
                            state_d = S_DONE;
                            halt_d  = 1'b1;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - DWELL_WIDTH'(1);
                    end
                end
                S_PAUSED: begin
                    // The resume cycle itself does not consume dwell.
                    if (!pause) begin
                        state_d = S_RUN;
                        halt_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    halt_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            endcase
        end

        // Step fields reach the outputs only on entry, so later table
        // writes to the active entry wait until it is re-entered.
        if (load) begin
            ld_step  = tab_q[load_idx];
            idx_d    = load_idx;
            freq_d   = ld_step.freq;
            wave_d   = ld_step.wave;
            duty_d   = ld_step.duty;
            rev_d    = ld_step.rev;
            cnt_d    = (ld_step.dwell == '0) ? DWELL_WIDTH'(1) : ld_step.dwell;
            strobe_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tab_q[i] <= '0;
            end
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            last_idx_q <= '0;
            freq_q     <= '0;
            wave_q     <= '0;
            duty_q     <= '0;
            rev_q      <= 1'b0;
            halt_q     <= 1'b1;
            busy_q     <= 1'b0;
            strobe_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                tab_q[i] <= tab_d[i];
            end
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            last_idx_q <= last_idx_d;
            freq_q     <= freq_d;
            wave_q     <= wave_d;
            duty_q     <= duty_d;
            rev_q      <= rev_d;
            halt_q     <= halt_d;
            busy_q     <= busy_d;
            strobe_q   <= strobe_d;
            done_q     <= done_d;
        end
    end

    assign freq_sel     = freq_q;
    assign wave_sel     = wave_q;
    assign rec_duty_cyc = duty_q;
    assign saw_reverse  = rev_q;
    assign halt         = halt_q;
    assign busy         = busy_q;
    assign step_idx     = idx_q;
    assign step_strobe  = strobe_q;
    assign done         = done_q;

endmodule

// File: tb/tb_waveform_seq_ctrl.sv
// tb/tb_waveform_seq_ctrl.sv - self-checking bench for waveform_seq_ctrl

module tb_waveform_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [7:0]  cfg_freq;
    logic [1:0]  cfg_wave;
    logic [7:0]  cfg_duty;
    logic        cfg_rev;
    logic [15:0] cfg_dwell;
    logic [3:0]  num_steps;
    logic        loop_en;
    logic        start;
    logic        stop;
    logic        pause;
    logic [7:0]  freq_sel;
    logic [1:0]  wave_sel;
    logic [7:0]  rec_duty_cyc;
    logic        saw_reverse;
    logic        halt;
    logic        busy;
    logic [2:0]  step_idx;
    logic        step_strobe;
    logic        done;

    waveform_seq_ctrl #(
        .SEL_WIDTH(8), .CNT_WIDTH(8), .DEPTH(8), .DWELL_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_freq(cfg_freq),
        .cfg_wave(cfg_wave), .cfg_duty(cfg_duty), .cfg_rev(cfg_rev),
        .cfg_dwell(cfg_dwell), .num_steps(num_steps), .loop_en(loop_en),
        .start(start), .stop(stop), .pause(pause),
        .freq_sel(freq_sel), .wave_sel(wave_sel), .rec_duty_cyc(rec_duty_cyc),
        .saw_reverse(saw_reverse), .halt(halt), .busy(busy),
        .step_idx(step_idx), .step_strobe(step_strobe), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit         dn;
        int         at;
        logic [2:0] idx;
        logic [7:0] f;
        logic [1:0] w;
        logic [7:0] d;
        logic       r;
    } exp_t;

    exp_t exp_q[$];

    logic [7:0] m_f  [8];
    logic [1:0] m_w  [8];
    logic [7:0] m_d  [8];
    logic       m_r  [8];
    int         m_dw [8];

    function automatic int dw_eff(int dw);
        return (dw == 0) ? 1 : dw;
    endfunction

    task automatic wait_cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_step(int a, int f, int w, int d, int r, int dw);
        cfg_addr  = a[2:0];
        cfg_freq  = f[7:0];
        cfg_wave  = w[1:0];
        cfg_duty  = d[7:0];
        cfg_rev   = r[0];
        cfg_dwell = dw[15:0];
        cfg_we    = 1'b1;
        m_f[a] = f[7:0]; m_w[a] = w[1:0]; m_d[a] = d[7:0]; m_r[a] = r[0]; m_dw[a] = dw;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic push_step(int idx, int at, bit dn);
        exp_t e;
        e.dn = dn; e.at = at; e.idx = idx[2:0];
        e.f = m_f[idx]; e.w = m_w[idx]; e.d = m_d[idx]; e.r = m_r[idx];
        exp_q.push_back(e);
    endtask

    task automatic start_seq(int n, bit lp);
        num_steps = n[3:0];
        loop_en   = lp;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Scoreboard: every strobe/done event must match the front expectation.
    always @(negedge clk) begin
        if (!rst && (step_strobe || done)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected cyc=%0d strobe=%b done=%b idx=%0d required no event",
                         cyc, step_strobe, done, step_idx);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (done !== e.dn || step_strobe !== !e.dn || cyc != e.at ||
                    step_idx !== e.idx || freq_sel !== e.f || wave_sel !== e.w ||
                    rec_duty_cyc !== e.d || saw_reverse !== e.r ||
                    halt !== e.dn || busy !== !e.dn) begin
                    errors++;
                    $display("FAIL sb_event got cyc=%0d done=%b idx=%0d f=%0d w=%0d d=%0d r=%b halt=%b busy=%b required cyc=%0d done=%b idx=%0d f=%0d w=%0d d=%0d r=%b",
                             cyc, done, step_idx, freq_sel, wave_sel, rec_duty_cyc, saw_reverse,
                             halt, busy, e.at, e.dn, e.idx, e.f, e.w, e.d, e.r);
                end
            end
        end
    end

    task automatic check_drained(string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending got=%0d required=0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        checks++;
        if ({halt, busy, step_strobe, done} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl got=%b required=1000", {halt, busy, step_strobe, done});
        end
        checks++;
        if ({freq_sel, wave_sel, rec_duty_cyc, saw_reverse, step_idx} !== 22'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h required=0",
                     {freq_sel, wave_sel, rec_duty_cyc, saw_reverse, step_idx});
        end
    endtask

    task automatic test_basic;
        int c0;
        write_step(0, 10, 1, 20, 0, 4);
        write_step(1, 33, 2, 0, 1, 2);
        write_step(2, 55, 3, 128, 0, 0);
        c0 = cyc;
        push_step(0, c0 + 1, 0);
        push_step(1, c0 + 5, 0);
        push_step(2, c0 + 7, 0);
        push_step(2, c0 + 8, 1);
        start_seq(3, 0);
        wait_cyc(8);
        checks++;
        if ({halt, busy} !== 2'b10) begin
            errors++;
            $display("FAIL basic_end got halt,busy=%b required=10", {halt, busy});
        end
        check_drained("basic");
    endtask

    task automatic test_back_to_back;
        int c0;
        c0 = cyc;
        push_step(0, c0 + 1, 0);
        push_step(0, c0 + 1 + dw_eff(m_dw[0]), 1);
        start_seq(1, 0);
        wait_cyc(dw_eff(m_dw[0]) + 1);
        check_drained("back_to_back");
    endtask

    task automatic test_loop_stop;
        int c0;
        write_step(0, 70, 0, 5, 1, 3);
        write_step(1, 71, 1, 6, 0, 3);
        c0 = cyc;
        for (int k = 0; k < 6; k++) push_step(k % 2, c0 + 1 + 3 * k, 0);
        start_seq(2, 1);
        wait_cyc(16);
        stop = 1'b1;
        wait_cyc(1);
        stop = 1'b0;
        checks++;
        if ({halt, busy, done, step_idx} !== 6'b100001) begin
            errors++;
            $display("FAIL loop_stop got halt,busy,done,idx=%b required=100001",
                     {halt, busy, done, step_idx});
        end
        wait_cyc(4);
        check_drained("loop_stop");
    endtask

    task automatic test_pause;
        int c0;
        write_step(0, 40, 2, 9, 1, 6);
        write_step(1, 41, 3, 8, 0, 2);
        c0 = cyc;
        push_step(0, c0 + 1, 0);
        push_step(1, c0 + 13, 0);
        push_step(1, c0 + 15, 1);
        start_seq(2, 0);
        wait_cyc(2);
        pause = 1'b1;
        wait_cyc(2);
        checks++;
        if ({halt, busy, step_idx, freq_sel} !== {1'b1, 1'b1, 3'd0, 8'd40}) begin
            errors++;
            $display("FAIL pause_frozen got halt=%b busy=%b idx=%0d f=%0d required 1 1 0 40",
                     halt, busy, step_idx, freq_sel);
        end
        wait_cyc(3);
        pause = 1'b0;
        wait_cyc(2);
        checks++;
        if ({halt, busy} !== 2'b01) begin
            errors++;
            $display("FAIL pause_resume got halt,busy=%b required=01", {halt, busy});
        end
        wait_cyc(6);
        check_drained("pause");
    endtask

    task automatic test_start_stop;
        num_steps = 4'd2;
        loop_en   = 1'b0;
        start     = 1'b1;
        stop      = 1'b1;
        wait_cyc(1);
        start = 1'b0;
        stop  = 1'b0;
        checks++;
        if ({halt, busy} !== 2'b10) begin
            errors++;
            $display("FAIL start_stop got halt,busy=%b required=10", {halt, busy});
        end
        wait_cyc(3);
        check_drained("start_stop");
    endtask

    task automatic test_num_steps;
        int c0;
        int at;
        start_seq(0, 0);
        checks++;
        if ({busy, halt, step_strobe} !== 3'b010) begin
            errors++;
            $display("FAIL num0_ignored got busy,halt,strobe=%b required=010",
                     {busy, halt, step_strobe});
        end
        wait_cyc(2);
        for (int i = 0; i < 8; i++) write_step(i, 100 + i, i % 4, 3 * i, i % 2, i % 3);
        c0 = cyc;
        at = c0 + 1;
        for (int i = 0; i < 8; i++) begin
            push_step(i, at, 0);
            at += dw_eff(m_dw[i]);
        end
        push_step(7, at, 1);
        start_seq(15, 0);
        wait_cyc(at - c0);
        check_drained("num_steps");
    endtask

    task automatic test_cfg_write;
        int c0;
        write_step(0, 1, 0, 0, 0, 4);
        write_step(1, 2, 1, 1, 1, 4);
        c0 = cyc;
        push_step(0, c0 + 1, 0);
        push_step(1, c0 + 5, 0);
        start_seq(2, 1);
        write_step(0, 99, 3, 77, 1, 4);
        push_step(0, c0 + 9, 0);
        checks++;
        if ({step_idx, freq_sel, wave_sel} !== {3'd0, 8'd1, 2'd0}) begin
            errors++;
            $display("FAIL cfg_active got idx=%0d f=%0d w=%0d required 0 1 0",
                     step_idx, freq_sel, wave_sel);
        end
        wait_cyc(8);
        stop = 1'b1;
        wait_cyc(1);
        stop = 1'b0;
        wait_cyc(2);
        check_drained("cfg_write");
    endtask

    task automatic test_reset_mid;
        int c0;
        write_step(0, 77, 2, 33, 1, 10);
        c0 = cyc;
        push_step(0, c0 + 1, 0);
        start_seq(1, 0);
        wait_cyc(1);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        checks++;
        if ({halt, busy, step_strobe, done, freq_sel, wave_sel, rec_duty_cyc, saw_reverse, step_idx}
            !== {4'b1000, 22'd0}) begin
            errors++;
            $display("FAIL reset_mid got halt=%b busy=%b f=%0d w=%0d d=%0d r=%b idx=%0d required 1 0 0 0 0 0 0",
                     halt, busy, freq_sel, wave_sel, rec_duty_cyc, saw_reverse, step_idx);
        end
        check_drained("reset_mid_run");
        for (int i = 0; i < 8; i++) begin
            m_f[i] = '0; m_w[i] = '0; m_d[i] = '0; m_r[i] = 1'b0; m_dw[i] = 0;
        end
        c0 = cyc;
        push_step(0, c0 + 1, 0);
        push_step(0, c0 + 2, 1);
        start_seq(1, 0);
        wait_cyc(3);
        check_drained("reset_mid_table");
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_freq = '0; cfg_wave = '0;
        cfg_duty = '0; cfg_rev = 1'b0; cfg_dwell = '0; num_steps = '0;
        loop_en = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_f[i] = '0; m_w[i] = '0; m_d[i] = '0; m_r[i] = 1'b0; m_dw[i] = 0;
        end
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_loop_stop();
        test_pause();
        test_start_stop();
        test_num_steps();
        test_cfg_write();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
